// File: rtl/pid_pkg.sv
// Shared types and constants for the pid core host.
package pid_pkg;

   localparam int unsigned D_WIDTH_DEF = 16;

   localparam int unsigned ADDR_KP   = 0;
   localparam int unsigned ADDR_KI   = 1;
   localparam int unsigned ADDR_KD1  = 2;
   localparam int unsigned ADDR_KD2  = 3;
   localparam int unsigned ADDR_PARK = 4;

   typedef enum logic [2:0] {
      UNCFG,
      LOAD,
      RUN,
      ISSUE,
      WAIT
   } state_t;

endpackage

// File: rtl/pid_sat.sv
// Combinational signed clamp of a core result into [LIM_MIN, LIM_MAX].
module pid_sat
   import pid_pkg::*;
#(
   parameter int unsigned D_WIDTH = D_WIDTH_DEF,
   parameter int          LIM_MAX = 4096,
   parameter int          LIM_MIN = -4096
) (
   input  logic [D_WIDTH-1:0] din,
   output logic [D_WIDTH-1:0] dout_c
);

   localparam logic signed [D_WIDTH-1:0] MAX_V = D_WIDTH'(LIM_MAX);
   localparam logic signed [D_WIDTH-1:0] MIN_V = D_WIDTH'(LIM_MIN);

   // clamp against the signed bounds
   always_comb begin
      dout_c = din;
      if ($signed(din) > MAX_V) begin
         dout_c = MAX_V;
      end else if ($signed(din) < MIN_V) begin
         dout_c = MIN_V;
      end
   end

endmodule

// File: rtl/pid_host.sv
// Host for the pid core: loads gains, issues one iteration per tick, clamps results.
module pid_host
   import pid_pkg::*;
#(
   parameter int unsigned D_WIDTH        = D_WIDTH_DEF,
   parameter int          LIM_MAX        = 4096,
   parameter int          LIM_MIN        = -4096,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [D_WIDTH-1:0] cfg_kp,
   input  logic [D_WIDTH-1:0] cfg_ki,
   input  logic [D_WIDTH-1:0] cfg_kd1,
   input  logic [D_WIDTH-1:0] cfg_kd2,
   input  logic               sample_tick,
   input  logic [D_WIDTH-1:0] target_in,
   input  logic [D_WIDTH-1:0] meas_in,
   input  logic               err_clr,
   output logic               pid_write_enable,
   output logic               pid_iterate_enable,
   output logic [D_WIDTH-1:0] pid_reg_addr,
   output logic [D_WIDTH-1:0] pid_reg_data,
   output logic [D_WIDTH-1:0] pid_target,
   output logic [D_WIDTH-1:0] pid_measurement,
   input  logic [D_WIDTH-1:0] pid_out,
   input  logic               pid_out_valid,
   output logic [D_WIDTH-1:0] cmd_out,
   output logic               cmd_valid,
   output logic               busy,
   output logic               timeout_err,
   output logic               overrun_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state, state_nx;
   logic [1:0]         load_idx, load_idx_nx;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
   logic [D_WIDTH-1:0] kp_q, ki_q, kd1_q, kd2_q;
   logic [D_WIDTH-1:0] kp_nx, ki_nx, kd1_nx, kd2_nx;
   logic               cfg_acc, tick_acc, result_hit, timeout_hit, overrun_hit;
   logic               we_d, iter_d, ready_d, busy_d;
   logic [D_WIDTH-1:0] addr_d, data_d, sat_c;

   pid_sat #(
      .D_WIDTH (D_WIDTH),
      .LIM_MAX (LIM_MAX),
      .LIM_MIN (LIM_MIN)
   ) u_sat (
      .din    (pid_out),
      .dout_c (sat_c)
   );

   // state register with load index and wait counter
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state    <= UNCFG;
         load_idx <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         load_idx <= load_idx_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // next state and the events that drive datapath and error flags
   always_comb begin
      state_nx    = state;
      load_idx_nx = load_idx;
      wait_cnt_nx = wait_cnt;
      cfg_acc     = 1'b0;
      tick_acc    = 1'b0;
      result_hit  = 1'b0;
      timeout_hit = 1'b0;
      overrun_hit = 1'b0;
      case (state)
         UNCFG: begin
            if (cfg_valid && cfg_ready) begin
               cfg_acc     = 1'b1;
               state_nx    = LOAD;
               load_idx_nx = '0;
            end
         end
         LOAD: begin
            overrun_hit = sample_tick;
            if (load_idx == 2'd3) begin
               state_nx = RUN;
            end else begin
               load_idx_nx = load_idx + 2'd1;
            end
         end
         RUN: begin
            if (cfg_valid && cfg_ready) begin
               cfg_acc     = 1'b1;
               overrun_hit = sample_tick;
               state_nx    = LOAD;
               load_idx_nx = '0;
            end else if (sample_tick) begin
               tick_acc = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            overrun_hit = sample_tick;
            wait_cnt_nx = '0;
            state_nx    = WAIT;
         end
         WAIT: begin
            overrun_hit = sample_tick;
            if (pid_out_valid) begin
               result_hit = 1'b1;
               state_nx   = RUN;
            end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nx    = LOAD;
               load_idx_nx = '0;
            end else begin
               wait_cnt_nx = wait_cnt + CNT_W'(1);
            end
         end
         default: state_nx = UNCFG;
      endcase
   end

   // shadow gain values as they will be after this edge
   always_comb begin
      kp_nx  = cfg_acc ? cfg_kp  : kp_q;
      ki_nx  = cfg_acc ? cfg_ki  : ki_q;
      kd1_nx = cfg_acc ? cfg_kd1 : kd1_q;
      kd2_nx = cfg_acc ? cfg_kd2 : kd2_q;
   end

   // output decode from the upcoming state so the port registers line up with it
   always_comb begin
      we_d    = 1'b0;
      iter_d  = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      addr_d  = D_WIDTH'(ADDR_PARK);
      data_d  = '0;
      case (state_nx)
         UNCFG: ready_d = 1'b1;
         LOAD: begin
            busy_d = 1'b1;
            addr_d = D_WIDTH'(load_idx_nx);
            case (load_idx_nx)
               2'(ADDR_KP):  data_d = kp_nx;
               2'(ADDR_KI):  data_d = ki_nx;
               2'(ADDR_KD1): data_d = kd1_nx;
               2'(ADDR_KD2): data_d = kd2_nx;
               default:      data_d = '0;
            endcase
         end
         RUN: begin
            we_d    = 1'b1;
            ready_d = 1'b1;
         end
         ISSUE: begin
            we_d   = 1'b1;
            iter_d = 1'b1;
            busy_d = 1'b1;
         end
         WAIT: begin
            we_d   = 1'b1;
            busy_d = 1'b1;
         end
         default: ;
      endcase
   end

   // registered ports, shadow gains, operands, command and sticky errors
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pid_write_enable   <= 1'b0;
         pid_iterate_enable <= 1'b0;
         cfg_ready          <= 1'b0;
         busy               <= 1'b0;
         pid_reg_addr       <= D_WIDTH'(ADDR_PARK);
         pid_reg_data       <= '0;
         kp_q               <= '0;
         ki_q               <= '0;
         kd1_q              <= '0;
         kd2_q              <= '0;
         pid_target         <= '0;
         pid_measurement    <= '0;
         cmd_out            <= '0;
         cmd_valid          <= 1'b0;
         timeout_err        <= 1'b0;
         overrun_err        <= 1'b0;
      end else begin
         pid_write_enable   <= we_d;
         pid_iterate_enable <= iter_d;
         cfg_ready          <= ready_d;
         busy               <= busy_d;
         pid_reg_addr       <= addr_d;
         pid_reg_data       <= data_d;
         kp_q               <= kp_nx;
         ki_q               <= ki_nx;
         kd1_q              <= kd1_nx;
         kd2_q              <= kd2_nx;
         if (tick_acc) begin
            pid_target      <= target_in;
            pid_measurement <= meas_in;
         end
         if (result_hit) begin
            cmd_out <= sat_c;
         end
         cmd_valid   <= result_hit;
         timeout_err <= timeout_hit | (timeout_err & ~err_clr);
         overrun_err <= overrun_hit | (overrun_err & ~err_clr);
      end
   end

endmodule
